// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Fetch-side branch predictor: a direct-mapped branch target buffer (BTB) whose
// entries also carry a 2-bit saturating direction counter and a jump bit.
// Fetch presents a PC and the prediction comes back one cycle later from
// registers. The branch unit feeds resolved outcomes back to train the table.
// Two saturating performance counters track resolved branches and mispredicts.
//
// Ports
//   clk               : clock, rising edge
//   rst_n             : synchronous active-low reset
//   lookup_valid      : fetch requests a prediction for lookup_pc
//   lookup_pc         : fetch PC (bits [1:0] ignored)
//   flush             : pipeline redirect, kills the prediction in flight
//   pred_valid        : registered prediction valid
//   pred_taken        : registered predicted direction
//   pred_target       : registered predicted next PC (target or pc+4)
//   update_valid      : one resolved branch/jump this cycle
//   update_pc         : PC of the resolved instruction
//   update_taken      : actual direction
//   update_target     : actual taken target
//   update_is_jump    : resolved instruction is an unconditional jump
//   update_mispredict : branch unit flagged a mispredict
//   branch_count      : saturating count of resolved updates
//   mispredict_count  : saturating count of mispredicted updates
// -----------------------------------------------------------------------------
module branch_predictor #(
   parameter int unsigned ENTRIES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        lookup_valid,
   input  logic [31:0] lookup_pc,
   input  logic        flush,
   output logic        pred_valid,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        update_valid,
   input  logic [31:0] update_pc,
   input  logic        update_taken,
   input  logic [31:0] update_target,
   input  logic        update_is_jump,
   input  logic        update_mispredict,
   output logic [31:0] branch_count,
   output logic [31:0] mispredict_count
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = 30 - IDX_W;

   // ---------------------------------------------------------------------------
   // Table state
   // ---------------------------------------------------------------------------
   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [31:0]      target_q [ENTRIES];
   logic             jump_q   [ENTRIES];
   logic [1:0]       ctr_q    [ENTRIES];

   // Registered prediction and performance counters
   logic        pred_valid_q;
   logic        pred_taken_q;
   logic [31:0] pred_target_q;
   logic [31:0] branch_count_q;
   logic [31:0] mispredict_count_q;

   // PC bits [1:0] carry no information for word-aligned instructions
   logic unused_pc_lsbs;
   assign unused_pc_lsbs = ^{lookup_pc[1:0], update_pc[1:0]};

   // ---------------------------------------------------------------------------
   // Lookup path (reads current table contents, so a same-edge update is not
   // visible to the lookup sampled on that edge)
   // ---------------------------------------------------------------------------
   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic             lk_hit;
   logic             lk_taken;
   logic [31:0]      lk_target;

   always_comb begin
      lk_idx    = lookup_pc[IDX_W+1:2];
      lk_tag    = lookup_pc[31:IDX_W+2];
      lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      // Jumps are always taken regardless of counter state
      lk_taken  = lk_hit && (jump_q[lk_idx] || ctr_q[lk_idx][1]);
      lk_target = lk_taken ? target_q[lk_idx] : (lookup_pc + 32'd4);
   end

   // ---------------------------------------------------------------------------
   // Update path
   // ---------------------------------------------------------------------------
   logic [IDX_W-1:0] up_idx;
   logic [TAG_W-1:0] up_tag;
   logic             up_hit;
   logic [1:0]       up_ctr_cur;
   logic [1:0]       up_ctr_d;

   always_comb begin
      up_idx     = update_pc[IDX_W+1:2];
      up_tag     = update_pc[31:IDX_W+2];
      up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
      up_ctr_cur = ctr_q[up_idx];
      up_ctr_d   = up_ctr_cur;
      if (update_taken) begin
         if (up_ctr_cur != 2'b11) begin
            up_ctr_d = up_ctr_cur + 2'd1;
         end
      end else begin
         if (up_ctr_cur != 2'b00) begin
            up_ctr_d = up_ctr_cur - 2'd1;
         end
      end
   end

   // Tag, target and jump are not reset; valid = 0 makes them don't-care.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= 2'b01;
         end
      end else if (update_valid) begin
         if (up_hit) begin
            ctr_q[up_idx]  <= up_ctr_d;
            jump_q[up_idx] <= update_is_jump;
            if (update_taken) begin
               target_q[up_idx] <= update_target;
            end
         end else if (update_taken) begin
            // Taken miss allocates, silently evicting any aliasing entry
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= update_target;
            jump_q[up_idx]   <= update_is_jump;
            ctr_q[up_idx]    <= 2'b10;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Prediction registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pred_valid_q  <= 1'b0;
         pred_taken_q  <= 1'b0;
         pred_target_q <= 32'd0;
      end else begin
         pred_valid_q <= lookup_valid && !flush;
         // On idle cycles direction and target hold their last values
         if (lookup_valid) begin
            pred_taken_q  <= lk_taken;
            pred_target_q <= lk_target;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Saturating performance counters
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         branch_count_q     <= 32'd0;
         mispredict_count_q <= 32'd0;
      end else if (update_valid) begin
         if (branch_count_q != 32'hFFFF_FFFF) begin
            branch_count_q <= branch_count_q + 32'd1;
         end
         if (update_mispredict && (mispredict_count_q != 32'hFFFF_FFFF)) begin
            mispredict_count_q <= mispredict_count_q + 32'd1;
         end
      end
   end

   assign pred_valid       = pred_valid_q;
   assign pred_taken       = pred_taken_q;
   assign pred_target      = pred_target_q;
   assign branch_count     = branch_count_q;
   assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed self-checking bench for branch_predictor with ENTRIES = 16
// (index = pc[5:2], tag = pc[31:6]). Inputs change 1 time unit after the
// rising edge and outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

   logic        clk;
   logic        rst_n;
   logic        lookup_valid;
   logic [31:0] lookup_pc;
   logic        flush;
   logic        pred_valid;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        update_valid;
   logic [31:0] update_pc;
   logic        update_taken;
   logic [31:0] update_target;
   logic        update_is_jump;
   logic        update_mispredict;
   logic [31:0] branch_count;
   logic [31:0] mispredict_count;

   int checks = 0;
   int errors = 0;

   branch_predictor #(
      .ENTRIES(16)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .lookup_valid      (lookup_valid),
      .lookup_pc         (lookup_pc),
      .flush             (flush),
      .pred_valid        (pred_valid),
      .pred_taken        (pred_taken),
      .pred_target       (pred_target),
      .update_valid      (update_valid),
      .update_pc         (update_pc),
      .update_taken      (update_taken),
      .update_target     (update_target),
      .update_is_jump    (update_is_jump),
      .update_mispredict (update_mispredict),
      .branch_count      (branch_count),
      .mispredict_count  (mispredict_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_update(input logic [31:0] pc, input logic taken,
                               input logic [31:0] tgt, input logic jump, input logic misp);
      update_valid      = 1'b1;
      update_pc         = pc;
      update_taken      = taken;
      update_target     = tgt;
      update_is_jump    = jump;
      update_mispredict = misp;
   endtask

   task automatic clear_update();
      update_valid      = 1'b0;
      update_pc         = 32'd0;
      update_taken      = 1'b0;
      update_target     = 32'd0;
      update_is_jump    = 1'b0;
      update_mispredict = 1'b0;
   endtask

   // One update, no lookup
   task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                      input logic jump, input logic misp);
      drive_update(pc, taken, tgt, jump, misp);
      lookup_valid = 1'b0;
      tick();
      clear_update();
   endtask

   // One lookup, no update
   task automatic look(input logic [31:0] pc, input logic fl);
      lookup_valid = 1'b1;
      lookup_pc    = pc;
      flush        = fl;
      tick();
      lookup_valid = 1'b0;
      flush        = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b0;
      lookup_valid = 1'b0;
      lookup_pc    = 32'd0;
      flush        = 1'b0;
      clear_update();
      tick();
      tick();
      rst_n = 1'b1;

      // Reset state
      check1 ("rst_valid",  pred_valid, 1'b0);
      check1 ("rst_taken",  pred_taken, 1'b0);
      check32("rst_target", pred_target, 32'h0000_0000);
      check32("rst_bc",     branch_count, 32'd0);
      check32("rst_mc",     mispredict_count, 32'd0);

      look(32'h0000_0100, 1'b0);
      check1 ("cold_valid",  pred_valid, 1'b1);
      check1 ("cold_taken",  pred_taken, 1'b0);
      check32("cold_target", pred_target, 32'h0000_0104);

      // Allocate and train
      upd(32'h0000_0100, 1'b1, 32'h0000_0080, 1'b0, 1'b1);
      check32("alloc_bc", branch_count, 32'd1);
      check32("alloc_mc", mispredict_count, 32'd1);
      look(32'h0000_0100, 1'b0);
      check1 ("alloc_taken",  pred_taken, 1'b1);
      check32("alloc_target", pred_target, 32'h0000_0080);

      upd(32'h0000_0100, 1'b0, 32'h0, 1'b0, 1'b1);
      upd(32'h0000_0100, 1'b0, 32'h0, 1'b0, 1'b1);
      look(32'h0000_0100, 1'b0);
      check1 ("nt_taken",  pred_taken, 1'b0);
      check32("nt_target", pred_target, 32'h0000_0104);

      upd(32'h0000_0100, 1'b1, 32'h0000_0080, 1'b0, 1'b0);
      upd(32'h0000_0100, 1'b1, 32'h0000_0080, 1'b0, 1'b0);
      upd(32'h0000_0100, 1'b1, 32'h0000_0080, 1'b0, 1'b0);
      look(32'h0000_0100, 1'b0);
      check1 ("t3_taken",  pred_taken, 1'b1);
      check32("t3_target", pred_target, 32'h0000_0080);
      // Saturated at 11: one not-taken leaves 10, still taken
      upd(32'h0000_0100, 1'b0, 32'h0, 1'b0, 1'b0);
      look(32'h0000_0100, 1'b0);
      check1 ("sat_taken", pred_taken, 1'b1);
      check32("train_bc",  branch_count, 32'd7);
      check32("train_mc",  mispredict_count, 32'd3);

      // Jump: allocates index 0 (tag 8), evicting 0x100
      upd(32'h0000_0200, 1'b1, 32'h0000_0400, 1'b1, 1'b0);
      look(32'h0000_0200, 1'b0);
      check1 ("jal_taken",  pred_taken, 1'b1);
      check32("jal_target", pred_target, 32'h0000_0400);
      look(32'h0000_0100, 1'b0);
      check1 ("evict100_taken",  pred_taken, 1'b0);
      check32("evict100_target", pred_target, 32'h0000_0104);
      // Drive ctr to 00; jump bit still forces taken
      upd(32'h0000_0200, 1'b0, 32'h0, 1'b1, 1'b0);
      upd(32'h0000_0200, 1'b0, 32'h0, 1'b1, 1'b0);
      look(32'h0000_0200, 1'b0);
      check1 ("jal_ctr0_taken",  pred_taken, 1'b1);
      check32("jal_ctr0_target", pred_target, 32'h0000_0400);

      // Aliasing: 0x240 shares index 0 with 0x200
      upd(32'h0000_0240, 1'b1, 32'h0000_0600, 1'b0, 1'b0);
      look(32'h0000_0200, 1'b0);
      check1 ("alias_taken",  pred_taken, 1'b0);
      check32("alias_target", pred_target, 32'h0000_0204);
      look(32'h0000_0240, 1'b0);
      check1 ("alias240_taken",  pred_taken, 1'b1);
      check32("alias240_target", pred_target, 32'h0000_0600);

      // Same-edge update and lookup: lookup sees pre-update contents
      drive_update(32'h0000_0300, 1'b1, 32'h0000_0500, 1'b0, 1'b0);
      lookup_valid = 1'b1;
      lookup_pc    = 32'h0000_0300;
      tick();
      clear_update();
      lookup_valid = 1'b0;
      check1 ("rbw_valid",  pred_valid, 1'b1);
      check1 ("rbw_taken",  pred_taken, 1'b0);
      check32("rbw_target", pred_target, 32'h0000_0304);
      look(32'h0000_0300, 1'b0);
      check1 ("rbw_next_taken",  pred_taken, 1'b1);
      check32("rbw_next_target", pred_target, 32'h0000_0500);

      // Flush kills the prediction, table untouched
      look(32'h0000_0300, 1'b1);
      check1 ("flush_valid", pred_valid, 1'b0);
      look(32'h0000_0300, 1'b0);
      check1 ("postflush_valid",  pred_valid, 1'b1);
      check1 ("postflush_taken",  pred_taken, 1'b1);
      check32("postflush_target", pred_target, 32'h0000_0500);

      // Idle cycle: valid drops, direction/target hold
      tick();
      check1 ("idle_valid",  pred_valid, 1'b0);
      check1 ("idle_taken",  pred_taken, 1'b1);
      check32("idle_target", pred_target, 32'h0000_0500);

      // pc+4 wraps modulo 2^32
      look(32'hFFFF_FFFC, 1'b0);
      check1 ("wrap_taken",  pred_taken, 1'b0);
      check32("wrap_target", pred_target, 32'h0000_0000);
      check32("mid_bc", branch_count, 32'd12);
      check32("mid_mc", mispredict_count, 32'd3);

      // Reset mid-operation: in-flight lookup and same-edge update discarded
      rst_n        = 1'b0;
      lookup_valid = 1'b1;
      lookup_pc    = 32'h0000_0300;
      drive_update(32'h0000_0300, 1'b1, 32'h0000_0700, 1'b0, 1'b1);
      tick();
      clear_update();
      lookup_valid = 1'b0;
      rst_n        = 1'b1;
      check1 ("rst2_valid",  pred_valid, 1'b0);
      check1 ("rst2_taken",  pred_taken, 1'b0);
      check32("rst2_target", pred_target, 32'h0000_0000);
      check32("rst2_bc",     branch_count, 32'd0);
      check32("rst2_mc",     mispredict_count, 32'd0);
      look(32'h0000_0300, 1'b0);
      check1 ("rst2_miss_taken",  pred_taken, 1'b0);
      check32("rst2_miss_target", pred_target, 32'h0000_0304);

      // Counters: five updates, two mispredicted
      for (int i = 0; i < 5; i++) begin
         upd(32'h0000_0010, 1'b0, 32'h0, 1'b0, (i < 2) ? 1'b1 : 1'b0);
      end
      check32("cnt_bc", branch_count, 32'd5);
      check32("cnt_mc", mispredict_count, 32'd2);
      // Not-taken misses leave the table alone
      look(32'h0000_0010, 1'b0);
      check1 ("ntmiss_taken", pred_taken, 1'b0);

      // Saturation of branch_count
      force dut.branch_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.branch_count_q;
      check32("preset_bc", branch_count, 32'hFFFF_FFFF);
      upd(32'h0000_0010, 1'b0, 32'h0, 1'b0, 1'b0);
      check32("sat_bc", branch_count, 32'hFFFF_FFFF);
      check32("sat_bc_mc", mispredict_count, 32'd2);

      // Saturation of mispredict_count
      force dut.mispredict_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.mispredict_count_q;
      upd(32'h0000_0010, 1'b0, 32'h0, 1'b0, 1'b1);
      check32("sat_mc", mispredict_count, 32'hFFFF_FFFF);
      check32("sat_mc_bc", branch_count, 32'hFFFF_FFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
